// File: rtl/row_fetch_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : row_fetch_scheduler
// Purpose  : Arbitrates a single VRAM port between display row fetches and
//            renderer accesses. A row is read as bursts of BURST_LEN words.
//            Between bursts, a pending renderer gets up to RENDER_SLOT
//            accesses. Read returns are tracked by a tag pipeline so that
//            data is routed back to the display or the renderer.
// Ports    : i_master_clk / i_reset_n     clock, async active-low reset
//            i_display_start/_address     row fetch request and base address
//            o_display_column/_data/_valid returned row word and its index
//            o_display_busy               row reads still to be issued
//            i_render_req/_write/_address/_wdata  renderer access request
//            o_render_ack                 access placed on the VRAM bus
//            o_render_rdata/_valid        renderer read return
//            o_vram_address/_read/_write/_wdata   registered VRAM command
//            i_vram_rdata                 VRAM data, READ_LATENCY after read
// Revision : 1.0 - initial release
// ============================================================================
module row_fetch_scheduler #(
  parameter int ROW_WORDS    = 256,
  parameter int BURST_LEN    = 16,
  parameter int RENDER_SLOT  = 4,
  parameter int READ_LATENCY = 2
) (
  input  logic        i_master_clk,
  input  logic        i_reset_n,
  input  logic        i_display_start,
  input  logic [19:0] i_display_address,
  output logic [8:0]  o_display_column,
  output logic [23:0] o_display_data,
  output logic        o_display_data_valid,
  output logic        o_display_busy,
  input  logic        i_render_req,
  input  logic        i_render_write,
  input  logic [19:0] i_render_address,
  input  logic [23:0] i_render_wdata,
  output logic        o_render_ack,
  output logic [23:0] o_render_rdata,
  output logic        o_render_rdata_valid,
  output logic [19:0] o_vram_address,
  output logic        o_vram_read,
  output logic        o_vram_write,
  output logic [23:0] o_vram_wdata,
  input  logic [23:0] i_vram_rdata
);

  localparam int BURST_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int SLOT_W  = (RENDER_SLOT > 1) ? $clog2(RENDER_SLOT) : 1;
  localparam logic [8:0]         LAST_INDEX = 9'(ROW_WORDS - 1);
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(BURST_LEN - 1);
  localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(RENDER_SLOT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DISP = 2'd1,
    REND = 2'd2
  } state_t;

  state_t             state, state_nx;
  logic [19:0]        base, base_nx;
  logic [8:0]         index, index_nx;
  logic [BURST_W-1:0] burst_cnt, burst_nx;
  logic [SLOT_W-1:0]  slot_cnt, slot_nx;
  logic               gen, gen_nx;

  logic        disp_issue, rend_issue;
  logic        cmd_read, cmd_write, cmd_ack, cmd_owner;
  logic [19:0] cmd_addr;
  logic [23:0] cmd_wdata;
  logic [8:0]  cmd_index;

  // Tag travelling alongside the command currently on the VRAM bus
  // (owner: 0 = display, 1 = renderer).
  logic        tag_owner, tag_gen;
  logic [8:0]  tag_index;

  logic [READ_LATENCY-1:0]       pipe_valid, pipe_owner, pipe_gen;
  logic [READ_LATENCY-1:0][8:0]  pipe_index;

  // --------------------------------------------------------------------------
  // Next-state and command selection
  // --------------------------------------------------------------------------
  always_comb begin
    state_nx   = state;
    base_nx    = base;
    index_nx   = index;
    burst_nx   = burst_cnt;
    slot_nx    = slot_cnt;
    gen_nx     = gen;
    disp_issue = 1'b0;
    rend_issue = 1'b0;

    // A start always wins: from IDLE it begins a row, elsewhere it aborts
    // the current row. No command is issued in the start cycle itself.
    if (i_display_start) begin
      state_nx = DISP;
      base_nx  = i_display_address;
      index_nx = '0;
      burst_nx = '0;
      slot_nx  = '0;
      gen_nx   = ~gen;
    end else begin
      case (state)
        IDLE: begin
          rend_issue = i_render_req;
        end
        DISP: begin
          disp_issue = 1'b1;
          index_nx   = index + 9'd1;
          if (index == LAST_INDEX) begin
            state_nx = IDLE;
          end else if (burst_cnt == BURST_LAST) begin
            burst_nx = '0;
            if (i_render_req) begin
              state_nx = REND;
              slot_nx  = '0;
            end
          end else begin
            burst_nx = burst_cnt + 1'b1;
          end
        end
        REND: begin
          if (i_render_req) begin
            rend_issue = 1'b1;
            if (slot_cnt == SLOT_LAST) begin
              state_nx = DISP;
            end else begin
              slot_nx = slot_cnt + 1'b1;
            end
          end else begin
            state_nx = DISP;
          end
        end
        default: state_nx = IDLE;
      endcase
    end

    cmd_read  = 1'b0;
    cmd_write = 1'b0;
    cmd_ack   = 1'b0;
    cmd_owner = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_index = '0;
    if (disp_issue) begin
      cmd_read  = 1'b1;
      cmd_addr  = base + {11'd0, index};   // 20-bit wrap is intended
      cmd_index = index;
    end else if (rend_issue) begin
      cmd_read  = ~i_render_write;
      cmd_write = i_render_write;
      cmd_addr  = i_render_address;
      cmd_wdata = i_render_write ? i_render_wdata : 24'd0;
      cmd_ack   = 1'b1;
      cmd_owner = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // State, command register and return-tag pipeline
  // --------------------------------------------------------------------------
  always_ff @(posedge i_master_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state          <= IDLE;
      base           <= '0;
      index          <= '0;
      burst_cnt      <= '0;
      slot_cnt       <= '0;
      gen            <= 1'b0;
      o_vram_read    <= 1'b0;
      o_vram_write   <= 1'b0;
      o_vram_address <= '0;
      o_vram_wdata   <= '0;
      o_render_ack   <= 1'b0;
      tag_owner      <= 1'b0;
      tag_gen        <= 1'b0;
      tag_index      <= '0;
      pipe_valid     <= '0;
      pipe_owner     <= '0;
      pipe_gen       <= '0;
      pipe_index     <= '0;
    end else begin
      state          <= state_nx;
      base           <= base_nx;
      index          <= index_nx;
      burst_cnt      <= burst_nx;
      slot_cnt       <= slot_nx;
      gen            <= gen_nx;
      o_vram_read    <= cmd_read;
      o_vram_write   <= cmd_write;
      o_vram_address <= cmd_addr;
      o_vram_wdata   <= cmd_wdata;
      o_render_ack   <= cmd_ack;
      tag_owner      <= cmd_owner;
      tag_gen        <= gen;
      tag_index      <= cmd_index;
      // Stage 0 is loaded from the bus cycle, so the last stage lines up
      // with the cycle in which i_vram_rdata is valid.
      pipe_valid[0]  <= o_vram_read;
      pipe_owner[0]  <= tag_owner;
      pipe_gen[0]    <= tag_gen;
      pipe_index[0]  <= tag_index;
      for (int k = 1; k < READ_LATENCY; k++) begin
        pipe_valid[k] <= pipe_valid[k-1];
        pipe_owner[k] <= pipe_owner[k-1];
        pipe_gen[k]   <= pipe_gen[k-1];
        pipe_index[k] <= pipe_index[k-1];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Return routing. Display reads issued before the latest start carry a
  // stale generation and are dropped. Data is gated so idle outputs read 0.
  // --------------------------------------------------------------------------
  logic ret_valid, ret_owner, ret_gen;
  assign ret_valid = pipe_valid[READ_LATENCY-1];
  assign ret_owner = pipe_owner[READ_LATENCY-1];
  assign ret_gen   = pipe_gen[READ_LATENCY-1];

  assign o_display_data_valid = ret_valid & ~ret_owner & (ret_gen == gen);
  assign o_display_column     = o_display_data_valid ? pipe_index[READ_LATENCY-1] : 9'd0;
  assign o_display_data       = o_display_data_valid ? i_vram_rdata : 24'd0;
  assign o_render_rdata_valid = ret_valid & ret_owner;
  assign o_render_rdata       = o_render_rdata_valid ? i_vram_rdata : 24'd0;
  assign o_display_busy       = (state != IDLE);

endmodule
`default_nettype wire
